// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson phase monitor: FSM states, phase-width
// calculation and a width-generic Johnson code decoder.
package johnson_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOCKED  = 2'd2
    } jpm_state_t;

    // Largest ring the generic decoder handles; narrower codes are zero-padded.
    localparam int MAX_W = 16;

    typedef struct packed {
        logic       legal;
        logic [7:0] idx;
    } jdec_t;

    function automatic int PHASE_W(input int width);
        return $clog2(2 * width);
    endfunction

    // Phase k<=width: k leading ones; phase k>width: k-width leading zeros, rest ones.
    function automatic jdec_t johnson_decode_f(input logic [MAX_W-1:0] code, input int width);
        jdec_t            r;
        logic [MAX_W-1:0] pat;
        r = '0;
        for (int k = 0; k < 2 * MAX_W; k++) begin
            if (k < 2 * width) begin
                pat = '0;
                for (int i = 0; i < MAX_W; i++) begin
                    if (i < width) begin
                        pat[i] = (k <= width) ? (i < k) : (i >= k - width);
                    end
                end
                if (pat == code) begin
                    r.legal = 1'b1;
                    r.idx   = 8'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder: code -> legal flag, binary index, one-hot strobe.
module johnson_decode
    import johnson_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int PW    = PHASE_W(WIDTH)
) (
    input  logic [0:WIDTH-1]   i_code,
    output logic               o_legal,
    output logic [PW-1:0]      o_index,
    output logic [2*WIDTH-1:0] o_onehot
);

    logic [MAX_W-1:0] w_code;
    jdec_t            w_dec;

    always_comb begin
        w_code = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_code[i] = i_code[i];
        end
    end

    assign w_dec    = johnson_decode_f(w_code, WIDTH);
    assign o_legal  = w_dec.legal;
    assign o_index  = PW'(w_dec.idx);
    assign o_onehot = w_dec.legal ? ((2*WIDTH)'(1) << w_dec.idx) : '0;

endmodule

// File: rtl/johnson_phase_monitor.sv
// Johnson ring phase monitor: decode, legality/sequence checking, lock FSM, error count.
// Optional bidirectional tracking and the dir output are enabled by JPM_REVERSE_EN.
module johnson_phase_monitor
    import johnson_pkg::*;
#(
    parameter  int WIDTH      = 4,
    parameter  int LOCK_COUNT = 4,
    parameter  int ERR_CNT_W  = 8,
    localparam int PW         = PHASE_W(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [0:WIDTH-1]     code_in,
    input  logic                 code_valid,
    input  logic                 clr_err,
    output logic [PW-1:0]        phase,
    output logic [2*WIDTH-1:0]   phase_onehot,
    output logic                 phase_valid,
    output logic                 illegal,
    output logic                 seq_err,
    output logic                 locked,
`ifdef JPM_REVERSE_EN
    output logic                 dir,
`endif
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int GW = $clog2(LOCK_COUNT + 1);

    logic                 w_legal;
    logic [PW-1:0]        w_idx;
    logic [2*WIDTH-1:0]   w_onehot;
    logic [PW-1:0]        w_succ;
    logic                 w_fwd;
    logic                 w_ok_track;
    logic                 w_ok_locked;
    jpm_state_t           w_state_nxt;
    logic [GW-1:0]        w_good_nxt;
    logic [PW-1:0]        w_prev_nxt;
    logic                 w_ill_nxt;
    logic                 w_seq_nxt;

    jpm_state_t           r_state;
    logic [GW-1:0]        r_good_cnt;
    logic [PW-1:0]        r_prev_phase;
    logic [PW-1:0]        r_phase;
    logic [2*WIDTH-1:0]   r_onehot;
    logic                 r_phase_valid;
    logic                 r_illegal;
    logic                 r_seq_err;
    logic                 r_locked;
    logic [ERR_CNT_W-1:0] r_err_count;

    johnson_decode #(.WIDTH(WIDTH)) u_decode (
        .i_code   (code_in),
        .o_legal  (w_legal),
        .o_index  (w_idx),
        .o_onehot (w_onehot)
    );

    assign w_succ = (r_prev_phase == PW'(2*WIDTH-1)) ? '0 : r_prev_phase + PW'(1);
    assign w_fwd  = (w_idx == w_succ);

`ifdef JPM_REVERSE_EN
    logic          w_rev;
    logic [PW-1:0] w_pred;
    logic          w_dir_nxt;
    logic          r_dir;

    assign w_pred      = (r_prev_phase == '0) ? PW'(2*WIDTH-1) : r_prev_phase - PW'(1);
    assign w_rev       = (w_idx == w_pred);
    assign w_ok_track  = w_fwd || w_rev;
    // Once locked, reversing direction is treated as a sequence break.
    assign w_ok_locked = r_dir ? w_fwd : w_rev;
    assign dir         = r_dir;
`else
    assign w_ok_track  = w_fwd;
    assign w_ok_locked = w_fwd;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_prev_nxt  = r_prev_phase;
        w_ill_nxt   = 1'b0;
        w_seq_nxt   = 1'b0;
`ifdef JPM_REVERSE_EN
        w_dir_nxt   = r_dir;
`endif
        if (code_valid) begin
            if (!w_legal) begin
                w_ill_nxt   = 1'b1;
                w_state_nxt = ACQUIRE;
                w_good_nxt  = '0;
            end else begin
                w_prev_nxt = w_idx;
                case (r_state)
                    ACQUIRE: begin
                        w_state_nxt = TRACK;
                        w_good_nxt  = '0;
                    end
                    TRACK: begin
                        if (w_ok_track) begin
`ifdef JPM_REVERSE_EN
                            w_dir_nxt = w_fwd;
`endif
                            if (r_good_cnt == GW'(LOCK_COUNT - 1)) begin
                                w_state_nxt = LOCKED;
                            end else begin
                                w_good_nxt = r_good_cnt + GW'(1);
                            end
                        end else begin
                            w_seq_nxt  = 1'b1;
                            w_good_nxt = '0;
                        end
                    end
                    LOCKED: begin
                        if (!w_ok_locked) begin
                            w_seq_nxt   = 1'b1;
                            w_state_nxt = TRACK;
                            w_good_nxt  = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = ACQUIRE;
                        w_good_nxt  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ACQUIRE;
            r_good_cnt    <= '0;
            r_prev_phase  <= '0;
            r_phase       <= '0;
            r_onehot      <= '0;
            r_phase_valid <= 1'b0;
            r_illegal     <= 1'b0;
            r_seq_err     <= 1'b0;
            r_locked      <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_good_cnt   <= w_good_nxt;
            r_prev_phase <= w_prev_nxt;
            r_illegal    <= w_ill_nxt;
            r_seq_err    <= w_seq_nxt;
            r_locked     <= (w_state_nxt == LOCKED);
            // An illegal sample keeps the last index but drops the strobe.
            if (code_valid) begin
                r_phase_valid <= w_legal;
                r_onehot      <= w_legal ? w_onehot : '0;
                if (w_legal) begin
                    r_phase <= w_idx;
                end
            end
            if (clr_err) begin
                r_err_count <= '0;
            end else if ((w_ill_nxt || w_seq_nxt) && !(&r_err_count)) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
        end
    end

`ifdef JPM_REVERSE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir <= 1'b0;
        end else begin
            r_dir <= w_dir_nxt;
        end
    end
`endif

    assign phase        = r_phase;
    assign phase_onehot = r_onehot;
    assign phase_valid  = r_phase_valid;
    assign illegal      = r_illegal;
    assign seq_err      = r_seq_err;
    assign locked       = r_locked;
    assign err_count    = r_err_count;

endmodule

// File: doc/johnson_phase_monitor.md
Name: johnson_phase_monitor

Overview:
Downstream consumer of the 4-stage Johnson ring counter. It samples the counter's code every enabled cycle and decodes it to a binary phase index and a one-hot phase strobe. It also checks code legality and sequence order, maintains a lock status, and keeps a saturating error count. The phase outputs feed clock-phase/strobe generation logic; locked and the error outputs go to the status/debug block.

Parameters:
WIDTH, 4, number of Johnson stages; the code space is 2*WIDTH legal states.
LOCK_COUNT, 4, consecutive correct transitions required to assert locked.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  rising-edge clock, shared with the counter
rst_n  input  1  asynchronous active-low reset
code_in  input  [0:WIDTH-1]  Johnson code from the counter; bit 0 is the leftmost bit in the sequence tables below
code_valid  input  1  sample enable; tie to 1 when the counter advances every clk
clr_err  input  1  synchronous clear of err_count
phase  output  $clog2(2*WIDTH)  decoded phase index
phase_onehot  output  2*WIDTH  bit[phase] set while phase_valid is high
phase_valid  output  1  phase and phase_onehot hold a legal decode
illegal  output  1  one-cycle pulse: sampled code is not a Johnson state
seq_err  output  1  one-cycle pulse: legal code that is not the expected successor
locked  output  1  sequence tracking established
err_count  output  ERR_CNT_W  saturating count of illegal + seq_err events

Behaviour:
- Reset (async assert, sync deassert assumed upstream): phase=0, phase_onehot=0, phase_valid=0, illegal=0, seq_err=0, locked=0, err_count=0, FSM=ACQUIRE, prev_phase=0.
- Decode for WIDTH=4, code_in bit 0 leftmost:
  - 0000->0, 1000->1, 1100->2, 1110->3, 1111->4, 0111->5, 0011->6, 0001->7.
  - General rule: phase k<=WIDTH means k leading ones, remainder zeros; phase k>WIDTH means k-WIDTH leading zeros, remainder ones.
  - All other codes are illegal.
- Latency: every output is registered, one cycle after the code_valid sample. When code_valid=0, all outputs hold, pulses drop to 0, and no check is performed.
- Illegal sample: illegal=1 and phase_valid=0; phase and phase_onehot hold their previous values, except onehot is forced to 0. FSM goes to ACQUIRE.
- Legal sample: phase_valid=1, phase=k, onehot=1<<k.
- Expected successor is (prev_phase+1) mod 2*WIDTH, so 7->0 wraps for WIDTH=4. A repeated code counts as a sequence error.
- FSM:
  - ACQUIRE: the first legal sample loads prev_phase with no sequence check, good_cnt=0, next state TRACK.
  - TRACK: a correct successor increments good_cnt; when good_cnt reaches LOCK_COUNT-1 on a correct transition, go to LOCKED, so locked rises with the output of the LOCK_COUNT-th correct transition. A wrong successor gives seq_err=1, good_cnt=0, stay in TRACK, prev_phase=new.
  - LOCKED: a correct successor stays LOCKED. A wrong successor gives seq_err=1, go to TRACK with good_cnt=0, locked=0 on the same output edge as seq_err.
  - Any state: an illegal code sends the FSM to ACQUIRE and clears locked.
- err_count increments by 1 per cycle when illegal or seq_err is asserted, and saturates at all-ones.
- clr_err has priority over an increment in the same cycle; the result is 0.
- Reset mid-operation: all state clears immediately and the first post-reset legal sample restarts ACQUIRE.

Optional Feature:
JPM_REVERSE_EN
- Defined:
  - The predecessor (prev_phase-1) mod 2*WIDTH is also accepted as a correct transition.
  - An extra output dir (1 bit, reset 0) is registered as 1 for forward and 0 for reverse.
  - A direction change while LOCKED is a seq_err.
- Undefined: only forward is legal, the dir port is absent, and predecessor codes raise seq_err.

Decomposition:
- Package johnson_pkg holds:
  - the FSM state enum (ACQUIRE, TRACK, LOCKED);
  - the PHASE_W = $clog2(2*WIDTH) constant function;
  - a decode function returning {legal, index}.
- One combinational sub-module, johnson_decode, wraps the decode function (code_in -> legal, index, onehot) so the counter's own testbench can reuse it.

Test Plan:
- Reset, then feed the full sequence 0000,1000,...,0001,0000 with code_valid=1. Expected: phase 0..7,0; no seq_err; locked=1 on the output of the 4th transition; err_count=0.
- While LOCKED, inject 1010. Expected: illegal=1 for one cycle, phase_valid=0, locked=0, err_count=1; the next legal code re-enters ACQUIRE.
- While LOCKED, skip from phase 2 (1100) to phase 4 (1111). Expected: seq_err=1, locked=0; relocks after 4 further correct transitions.
- Hold code_valid=0 for 5 cycles mid-sequence, then resume with the correct successor. Expected: outputs frozen, no errors, locked stays 1.
- Force 300 illegal samples with ERR_CNT_W=8. Expected: err_count saturates at 255. Then assert clr_err together with another illegal. Expected: err_count=0.
- With JPM_REVERSE_EN: run 0001->0011->0111->1111. Expected: dir=0, no seq_err, locked after 4 transitions. Without the macro, the same stimulus gives seq_err on every step.
